ptw_arbiter: RTL and testbench

- Shares one page-table walker (PTW) between N_REQ TLB miss requesters, e.g. ITLB and DTLB.
- Accepts one miss request at a time and grants round-robin.
- Forwards the granted request to the PTW and routes the walk response back to the owner.
- Sits between the TLBs' PTW request/response ports and the PTW.

---
 rtl/ptw_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_ptw_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ptw_arbiter.sv
// Round-robin arbiter sharing one page-table walker between N_REQ TLB miss requesters.
// Optional response watchdog enabled by defining PTW_ARB_TIMEOUT_EN.
module ptw_arbiter #(
  parameter int unsigned N_REQ          = 2,
  parameter int unsigned VPN_W          = 27,
  parameter int unsigned ASID_W         = 16,
  parameter int unsigned PPN_W          = 44,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  localparam int unsigned OWN_W         = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [N_REQ-1:0]        req_valid_i,
  output logic [N_REQ-1:0]        req_ready_o,
  input  logic [N_REQ*VPN_W-1:0]  req_vpn_i,
  input  logic [N_REQ*ASID_W-1:0] req_asid_i,
  input  logic [N_REQ-1:0]        req_store_i,
  input  logic [N_REQ-1:0]        req_fetch_i,
  input  logic [1:0]              prv_i,
  input  logic                    invalidate_i,
  output logic                    ptw_req_valid_o,
  input  logic                    ptw_ready_i,
  output logic [VPN_W-1:0]        ptw_req_vpn_o,
  output logic [ASID_W-1:0]       ptw_req_asid_o,
  output logic [1:0]              ptw_req_prv_o,
  output logic                    ptw_req_store_o,
  output logic                    ptw_req_fetch_o,
  input  logic                    ptw_resp_valid_i,
  input  logic [PPN_W-1:0]        ptw_resp_ppn_i,
  input  logic [1:0]              ptw_resp_level_i,
  input  logic [7:0]              ptw_resp_pte_i,
  input  logic                    ptw_resp_error_i,
  output logic [N_REQ-1:0]        resp_valid_o,
  output logic [PPN_W-1:0]        resp_ppn_o,
  output logic [1:0]              resp_level_o,
  output logic [7:0]              resp_pte_o,
  output logic                    resp_error_o,
  output logic                    busy_o,
  output logic [OWN_W-1:0]        owner_o
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

  state_e              state_q, state_d;
  logic [OWN_W-1:0]    rr_q, rr_d, owner_q, owner_d;
  logic [VPN_W-1:0]    vpn_q, vpn_d;
  logic [ASID_W-1:0]   asid_q, asid_d;
  logic                store_q, store_d, fetch_q, fetch_d;
  logic [N_REQ-1:0]    resp_valid_q, resp_valid_d;
  logic [PPN_W-1:0]    resp_ppn_q, resp_ppn_d;
  logic [1:0]          resp_level_q, resp_level_d;
  logic [7:0]          resp_pte_q, resp_pte_d;
  logic                resp_error_q, resp_error_d;

  logic                grant_any;
  logic [OWN_W-1:0]    grant_idx, idx_c;
  logic [VPN_W-1:0]    vpn_sel;
  logic [ASID_W-1:0]   asid_sel;

  // Search downward so the nearest requester after rr_q overwrites the others.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    idx_c     = '0;
    for (int i = int'(N_REQ); i >= 1; i--) begin
      idx_c = OWN_W'((int'(rr_q) + i) % int'(N_REQ));
      if (req_valid_i[idx_c]) begin
        grant_any = 1'b1;
        grant_idx = idx_c;
      end
    end
  end

  always_comb begin
    vpn_sel  = '0;
    asid_sel = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      if (grant_idx == OWN_W'(k)) begin
        vpn_sel  = req_vpn_i[k*VPN_W +: VPN_W];
        asid_sel = req_asid_i[k*ASID_W +: ASID_W];
      end
    end
  end

`ifdef PTW_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  logic unused_tmo;
  assign unused_tmo = ^CNT_W'(TIMEOUT_CYCLES);
`endif

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    owner_d      = owner_q;
    vpn_d        = vpn_q;
    asid_d       = asid_q;
    store_d      = store_q;
    fetch_d      = fetch_q;
    resp_valid_d = '0;
    resp_ppn_d   = resp_ppn_q;
    resp_level_d = resp_level_q;
    resp_pte_d   = resp_pte_q;
    resp_error_d = resp_error_q;
    req_ready_o  = '0;
`ifdef PTW_ARB_TIMEOUT_EN
    cnt_d = (state_q != IDLE) ? cnt_q + CNT_W'(1) : cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          req_ready_o[grant_idx] = 1'b1;
          vpn_d   = vpn_sel;
          asid_d  = asid_sel;
          store_d = req_store_i[grant_idx];
          fetch_d = req_fetch_i[grant_idx];
          owner_d = grant_idx;
          rr_d    = grant_idx;
          state_d = ISSUE;
`ifdef PTW_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ISSUE: begin
        if (ptw_ready_i)       state_d = WAIT;
        else if (invalidate_i) state_d = IDLE;
      end
      WAIT: begin
        if (ptw_resp_valid_i) begin
          resp_valid_d[owner_q] = 1'b1;
          resp_ppn_d   = ptw_resp_ppn_i;
          resp_level_d = ptw_resp_level_i;
          resp_pte_d   = ptw_resp_pte_i;
          resp_error_d = ptw_resp_error_i;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef PTW_ARB_TIMEOUT_EN
    // A real response in the expiry cycle wins over the synthetic error.
    if ((state_q != IDLE) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) &&
        !((state_q == WAIT) && ptw_resp_valid_i)) begin
      resp_valid_d          = '0;
      resp_valid_d[owner_q] = 1'b1;
      resp_ppn_d   = '0;
      resp_level_d = '0;
      resp_pte_d   = '0;
      resp_error_d = 1'b1;
      state_d      = IDLE;
    end
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      rr_q         <= OWN_W'(N_REQ - 1);
      owner_q      <= '0;
      vpn_q        <= '0;
      asid_q       <= '0;
      store_q      <= 1'b0;
      fetch_q      <= 1'b0;
      resp_valid_q <= '0;
      resp_ppn_q   <= '0;
      resp_level_q <= '0;
      resp_pte_q   <= '0;
      resp_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      owner_q      <= owner_d;
      vpn_q        <= vpn_d;
      asid_q       <= asid_d;
      store_q      <= store_d;
      fetch_q      <= fetch_d;
      resp_valid_q <= resp_valid_d;
      resp_ppn_q   <= resp_ppn_d;
      resp_level_q <= resp_level_d;
      resp_pte_q   <= resp_pte_d;
      resp_error_q <= resp_error_d;
    end
  end

`ifdef PTW_ARB_TIMEOUT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`endif

  assign ptw_req_valid_o = (state_q == ISSUE);
  assign ptw_req_vpn_o   = vpn_q;
  assign ptw_req_asid_o  = asid_q;
  assign ptw_req_prv_o   = prv_i;
  assign ptw_req_store_o = store_q;
  assign ptw_req_fetch_o = fetch_q;
  assign resp_valid_o    = resp_valid_q;
  assign resp_ppn_o      = resp_ppn_q;
  assign resp_level_o    = resp_level_q;
  assign resp_pte_o      = resp_pte_q;
  assign resp_error_o    = resp_error_q;
  assign busy_o          = (state_q != IDLE);
  assign owner_o         = owner_q;

endmodule

// File: tb/tb_ptw_arbiter.sv
// Directed self-checking bench for ptw_arbiter (N_REQ=2); timeout section runs when PTW_ARB_TIMEOUT_EN is defined.
module tb_ptw_arbiter;

  localparam int unsigned N_REQ  = 2;
  localparam int unsigned VPN_W  = 27;
  localparam int unsigned ASID_W = 16;
  localparam int unsigned PPN_W  = 44;
  localparam int unsigned OWN_W  = 1;

  logic                    clk_i = 1'b0;
  logic                    rst_i;
  logic [N_REQ-1:0]        req_valid_i;
  logic [N_REQ-1:0]        req_ready_o;
  logic [N_REQ*VPN_W-1:0]  req_vpn_i;
  logic [N_REQ*ASID_W-1:0] req_asid_i;
  logic [N_REQ-1:0]        req_store_i;
  logic [N_REQ-1:0]        req_fetch_i;
  logic [1:0]              prv_i;
  logic                    invalidate_i;
  logic                    ptw_req_valid_o;
  logic                    ptw_ready_i;
  logic [VPN_W-1:0]        ptw_req_vpn_o;
  logic [ASID_W-1:0]       ptw_req_asid_o;
  logic [1:0]              ptw_req_prv_o;
  logic                    ptw_req_store_o;
  logic                    ptw_req_fetch_o;
  logic                    ptw_resp_valid_i;
  logic [PPN_W-1:0]        ptw_resp_ppn_i;
  logic [1:0]              ptw_resp_level_i;
  logic [7:0]              ptw_resp_pte_i;
  logic                    ptw_resp_error_i;
  logic [N_REQ-1:0]        resp_valid_o;
  logic [PPN_W-1:0]        resp_ppn_o;
  logic [1:0]              resp_level_o;
  logic [7:0]              resp_pte_o;
  logic                    resp_error_o;
  logic                    busy_o;
  logic [OWN_W-1:0]        owner_o;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [VPN_W-1:0]  VPN0  = 27'h0001234;
  localparam logic [VPN_W-1:0]  VPN1  = 27'h0005678;
  localparam logic [ASID_W-1:0] ASID0 = 16'h00AA;
  localparam logic [ASID_W-1:0] ASID1 = 16'h00BB;

  ptw_arbiter #(
    .N_REQ(N_REQ), .VPN_W(VPN_W), .ASID_W(ASID_W), .PPN_W(PPN_W), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_vpn_i(req_vpn_i), .req_asid_i(req_asid_i),
    .req_store_i(req_store_i), .req_fetch_i(req_fetch_i),
    .prv_i(prv_i), .invalidate_i(invalidate_i),
    .ptw_req_valid_o(ptw_req_valid_o), .ptw_ready_i(ptw_ready_i),
    .ptw_req_vpn_o(ptw_req_vpn_o), .ptw_req_asid_o(ptw_req_asid_o),
    .ptw_req_prv_o(ptw_req_prv_o), .ptw_req_store_o(ptw_req_store_o),
    .ptw_req_fetch_o(ptw_req_fetch_o),
    .ptw_resp_valid_i(ptw_resp_valid_i), .ptw_resp_ppn_i(ptw_resp_ppn_i),
    .ptw_resp_level_i(ptw_resp_level_i), .ptw_resp_pte_i(ptw_resp_pte_i),
    .ptw_resp_error_i(ptw_resp_error_i),
    .resp_valid_o(resp_valid_o), .resp_ppn_o(resp_ppn_o),
    .resp_level_o(resp_level_o), .resp_pte_o(resp_pte_o),
    .resp_error_o(resp_error_o), .busy_o(busy_o), .owner_o(owner_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  // One full grant/issue/response round; called at a negedge while in IDLE.
  task automatic do_walk(input logic [1:0] valid, input int g, input logic [PPN_W-1:0] ppn);
    logic [1:0] onehot;
    onehot = 2'(1 << g);
    req_valid_i = valid;
    #1;
    check("grant_ready", 64'(req_ready_o), 64'(onehot));
    cyc();
    check("issue_valid", 64'(ptw_req_valid_o), 64'd1);
    check("issue_owner", 64'(owner_o), 64'(g));
    check("issue_vpn", 64'(ptw_req_vpn_o), 64'((g == 0) ? VPN0 : VPN1));
    check("issue_asid", 64'(ptw_req_asid_o), 64'((g == 0) ? ASID0 : ASID1));
    check("issue_store", 64'(ptw_req_store_o), 64'((g == 0) ? 1 : 0));
    check("issue_fetch", 64'(ptw_req_fetch_o), 64'((g == 0) ? 0 : 1));
    check("issue_noready", 64'(req_ready_o), 64'd0);
    ptw_ready_i = 1'b1;
    cyc();
    ptw_ready_i = 1'b0;
    check("wait_noreq", 64'(ptw_req_valid_o), 64'd0);
    check("wait_busy", 64'(busy_o), 64'd1);
    cyc();
    ptw_resp_valid_i = 1'b1;
    ptw_resp_ppn_i   = ppn;
    ptw_resp_level_i = 2'd1;
    ptw_resp_pte_i   = 8'hCF;
    ptw_resp_error_i = 1'b0;
    cyc();
    ptw_resp_valid_i = 1'b0;
    check("resp_valid", 64'(resp_valid_o), 64'(onehot));
    check("resp_ppn", 64'(resp_ppn_o), 64'(ppn));
    check("resp_level", 64'(resp_level_o), 64'd1);
    check("resp_pte", 64'(resp_pte_o), 64'hCF);
    check("resp_error", 64'(resp_error_o), 64'd0);
    check("resp_idle", 64'(busy_o), 64'd0);
  endtask

  initial begin
    rst_i            = 1'b1;
    req_valid_i      = '0;
    req_vpn_i        = {VPN1, VPN0};
    req_asid_i       = {ASID1, ASID0};
    req_store_i      = 2'b01;
    req_fetch_i      = 2'b10;
    prv_i            = 2'b00;
    invalidate_i     = 1'b0;
    ptw_ready_i      = 1'b0;
    ptw_resp_valid_i = 1'b0;
    ptw_resp_ppn_i   = '0;
    ptw_resp_level_i = '0;
    ptw_resp_pte_i   = '0;
    ptw_resp_error_i = 1'b0;
    cyc();
    cyc();
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_ptw_valid", 64'(ptw_req_valid_o), 64'd0);
    check("rst_resp_valid", 64'(resp_valid_o), 64'd0);
    check("rst_owner", 64'(owner_o), 64'd0);
    check("rst_vpn", 64'(ptw_req_vpn_o), 64'd0);
    rst_i = 1'b0;
    cyc();

    // Single request; response checked one cycle after ptw_resp_valid_i.
    do_walk(2'b01, 0, 44'hABC);
    req_valid_i = 2'b00;
    cyc();
    check("resp_one_cycle", 64'(resp_valid_o), 64'd0);
    prv_i = 2'b11;
    #1;
    check("prv_pass", 64'(ptw_req_prv_o), 64'd3);
    prv_i = 2'b00;

    // Round-robin with both held; last grant was 0, so 1 goes first.
    do_walk(2'b11, 1, 44'h111);
    do_walk(2'b11, 0, 44'h222);
    do_walk(2'b11, 1, 44'h333);
    do_walk(2'b11, 0, 44'h444);
    do_walk(2'b10, 1, 44'h555);
    req_valid_i = 2'b00;
    cyc();

    // Invalidate while ISSUE is stalled withdraws the request.
    req_valid_i = 2'b01;
    #1;
    check("inv_issue_grant", 64'(req_ready_o), 64'b01);
    cyc();
    req_valid_i  = 2'b00;
    invalidate_i = 1'b1;
    cyc();
    invalidate_i = 1'b0;
    check("inv_issue_busy", 64'(busy_o), 64'd0);
    check("inv_issue_noreq", 64'(ptw_req_valid_o), 64'd0);
    check("inv_issue_noresp", 64'(resp_valid_o), 64'd0);
    cyc();
    check("inv_issue_noresp2", 64'(resp_valid_o), 64'd0);

    // Invalidate in IDLE still grants; in ISSUE with ready it accepts; in WAIT is ignored.
    req_valid_i  = 2'b10;
    invalidate_i = 1'b1;
    #1;
    check("inv_idle_grant", 64'(req_ready_o), 64'b10);
    cyc();
    req_valid_i      = 2'b00;
    ptw_ready_i      = 1'b1;
    ptw_resp_valid_i = 1'b1;
    ptw_resp_ppn_i   = 44'hDEAD;
    cyc();
    ptw_ready_i      = 1'b0;
    ptw_resp_valid_i = 1'b0;
    check("issue_resp_ignored", 64'(resp_valid_o), 64'd0);
    check("inv_accept_busy", 64'(busy_o), 64'd1);
    for (int i = 0; i < 5; i++) cyc();
    check("inv_wait_busy", 64'(busy_o), 64'd1);
    ptw_resp_valid_i = 1'b1;
    ptw_resp_ppn_i   = 44'h77;
    ptw_resp_level_i = 2'd2;
    ptw_resp_pte_i   = 8'h01;
    ptw_resp_error_i = 1'b1;
    cyc();
    ptw_resp_valid_i = 1'b0;
    ptw_resp_error_i = 1'b0;
    invalidate_i     = 1'b0;
    check("inv_wait_resp", 64'(resp_valid_o), 64'b10);
    check("inv_wait_ppn", 64'(resp_ppn_o), 64'h77);
    check("inv_wait_err", 64'(resp_error_o), 64'd1);
    cyc();

    // Reset during WAIT aborts silently; rr_ptr returns to N_REQ-1.
    req_valid_i = 2'b01;
    cyc();
    req_valid_i = 2'b00;
    ptw_ready_i = 1'b1;
    cyc();
    ptw_ready_i = 1'b0;
    check("mid_busy", 64'(busy_o), 64'd1);
    rst_i = 1'b1;
    #1;
    check("mid_rst_busy", 64'(busy_o), 64'd0);
    check("mid_rst_ppn", 64'(resp_ppn_o), 64'd0);
    check("mid_rst_err", 64'(resp_error_o), 64'd0);
    check("mid_rst_vpn", 64'(ptw_req_vpn_o), 64'd0);
    cyc();
    rst_i            = 1'b0;
    ptw_resp_valid_i = 1'b1;
    ptw_resp_ppn_i   = 44'h99;
    cyc();
    ptw_resp_valid_i = 1'b0;
    check("late_resp_dropped", 64'(resp_valid_o), 64'd0);
    req_valid_i = 2'b11;
    #1;
    check("rst_rr_grant0", 64'(req_ready_o), 64'b01);
    cyc();
    req_valid_i = 2'b00;
    invalidate_i = 1'b1;
    cyc();
    invalidate_i = 1'b0;

`ifdef PTW_ARB_TIMEOUT_EN
    // Watchdog fires 8 cycles after ISSUE entry with an error response.
    req_valid_i = 2'b01;
    cyc();
    req_valid_i = 2'b00;
    ptw_ready_i = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      cyc();
      ptw_ready_i = 1'b0;
      check("tmo_pending", 64'(resp_valid_o), 64'd0);
    end
    cyc();
    check("tmo_valid", 64'(resp_valid_o), 64'b01);
    check("tmo_error", 64'(resp_error_o), 64'd1);
    check("tmo_ppn", 64'(resp_ppn_o), 64'd0);
    check("tmo_idle", 64'(busy_o), 64'd0);
    ptw_resp_valid_i = 1'b1;
    ptw_resp_ppn_i   = 44'h55;
    cyc();
    ptw_resp_valid_i = 1'b0;
    check("tmo_late_drop", 64'(resp_valid_o), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
